// File: rtl/mem_bus_arbiter_pkg.sv
// Shared CPU memory-arbiter definitions: arbiter state encoding, bus size codes,
// and the fairness threshold used when MEM_ARB_FAIRNESS_EN is defined.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_I = 3'd1,
        ST_ADDR_D = 3'd2,
        ST_WAIT_I = 3'd3,
        ST_WAIT_D = 3'd4
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Consecutive data grants tolerated while a fetch is waiting.
    localparam logic [1:0] FAIR_LIMIT = 2'd2;

    function automatic logic is_fetch_state(input arb_state_t s);
        return (s == ST_ADDR_I) || (s == ST_WAIT_I);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_hold_reg.sv
// Per-requester read-data register: passes bus data through in the completing
// cycle and keeps presenting the captured value afterwards.
module mem_arb_hold_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= din;
        end
    end

    assign dout = capture ? din : hold_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// data first; define MEM_ARB_FAIRNESS_EN to bound how long a fetch can be starved.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              i_stall,
    output logic              d_stall
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       kill_q;
    logic       kill_d;
    logic       kill_now;
    logic       fetch_busy;
    logic       grant_i;
    logic       grant_d;

    assign fetch_busy = is_fetch_state(state_q);
    // A flush arriving in the same cycle as the fetch response must already suppress it.
    assign kill_now   = kill_q | (flush & fetch_busy);

    assign inst_data_ok = (state_q == ST_WAIT_I) & bus_data_ok & ~kill_now;
    assign data_data_ok = (state_q == ST_WAIT_D) & bus_data_ok;

    assign i_stall = inst_req & ~inst_data_ok;
    assign d_stall = data_req & ~data_data_ok;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [1:0] fair_cnt_q;
    logic       fair_turn;

    assign fair_turn = inst_req & (fair_cnt_q == FAIR_LIMIT);
    assign grant_i   = inst_req & (~data_req | fair_turn);
    assign grant_d   = data_req & ~grant_i;

    // Counts data grants that overtook a waiting fetch; saturates by handing the next slot to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (grant_i) begin
                fair_cnt_q <= '0;
            end else if (grant_d) begin
                fair_cnt_q <= inst_req ? fair_cnt_q + 2'd1 : 2'd0;
            end
        end
    end
`else
    assign grant_d = data_req;
    assign grant_i = inst_req & ~data_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = SIZE_BYTE;
        bus_addr  = '0;
        bus_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d = ST_ADDR_D;
                end else if (grant_i) begin
                    state_d = ST_ADDR_I;
                end
            end
            ST_ADDR_I: begin
                bus_req  = 1'b1;
                bus_size = SIZE_WORD;
                bus_addr = inst_addr;
                if (bus_addr_ok) begin
                    state_d = ST_WAIT_I;
                end
            end
            ST_ADDR_D: begin
                bus_req   = 1'b1;
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                if (bus_addr_ok) begin
                    state_d = ST_WAIT_D;
                end
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The killed fetch still completes its bus handshake; the flag lives until IDLE.
        if (flush & fetch_busy) begin
            kill_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            kill_d = 1'b0;
        end
    end

    mem_arb_hold_reg #(
        .DATA_W (DATA_W)
    ) u_inst_hold (
        .clk     (clk),
        .rst     (rst),
        .capture (inst_data_ok),
        .din     (bus_rdata),
        .dout    (inst_rdata)
    );

    mem_arb_hold_reg #(
        .DATA_W (DATA_W)
    ) u_data_hold (
        .clk     (clk),
        .rst     (rst),
        .capture (data_data_ok),
        .din     (bus_rdata),
        .dout    (data_rdata)
    );

endmodule
